// File: rtl/camera_roi_capture_pkg.sv
// Shared types and constants for the MT9V034 ROI capture front end.
// The optional line-length checker in the top is enabled by CAM_LINE_CHECK_EN.
package cam_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } cam_state_e;

    localparam logic [1:0] DECIM_1_1 = 2'd0;
    localparam logic [1:0] DECIM_1_2 = 2'd1;
    localparam logic [1:0] DECIM_1_4 = 2'd2;
    localparam logic [1:0] DECIM_1_8 = 2'd3;

    localparam int H_DEF   = 752;
    localparam int V_DEF   = 480;
    localparam int FCW_DEF = 16;

    // Low-bit mask that must be zero for a position to land on the decimation grid.
    function automatic logic [2:0] decim_mask(input logic [1:0] decim);
        logic [2:0] mask;
        case (decim)
            DECIM_1_1: mask = 3'b000;
            DECIM_1_2: mask = 3'b001;
            DECIM_1_4: mask = 3'b011;
            DECIM_1_8: mask = 3'b111;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/camera_roi_capture_roi_axis.sv
// One axis of the ROI window: window membership, decimation phase and
// ROI-relative output coordinate. Purely combinational; counters live in the caller.
module roi_axis
    import cam_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW:0]   pos,
    input  logic [CW-1:0] origin,
    input  logic [CW:0]   extent,
    input  logic [1:0]    decim,
    output logic          in_win,
    output logic          phase_hit,
    output logic [CW-1:0] coord
);

    logic [CW+1:0] pos_w;
    logic [CW+1:0] lo_w;
    logic [CW+1:0] hi_w;
    logic [CW:0]   off;
    logic [CW:0]   mask;

    // Two guard bits so origin + extent beyond the sensor never wraps.
    assign pos_w = {1'b0, pos};
    assign lo_w  = {2'b00, origin};
    assign hi_w  = lo_w + {1'b0, extent};

    assign in_win    = (pos_w >= lo_w) && (pos_w < hi_w);
    assign off       = pos - {1'b0, origin};
    assign mask      = (CW+1)'(decim_mask(decim));
    assign phase_hit = ((off & mask) == '0);
    assign coord     = CW'(off >> decim);

endmodule

// File: rtl/camera_roi_capture.sv
// MT9V034 capture front end: frame sync, runtime ROI crop and power-of-two decimation.
// Define CAM_LINE_CHECK_EN to build the sticky line-length checker driving LINE_ERR.
module camera_roi_capture
    import cam_pkg::*;
#(
    parameter int DW  = 10,
    parameter int H   = H_DEF,
    parameter int V   = V_DEF,
    parameter int FCW = FCW_DEF
) (
    input  logic                 PIXCLK,
    input  logic                 RST_N,
    input  logic                 LINE_VALID,
    input  logic                 FRAME_VALID,
    input  logic [DW-1:0]        DATA_IN,
    input  logic [$clog2(H)-1:0] ROI_X0,
    input  logic [$clog2(V)-1:0] ROI_Y0,
    input  logic [$clog2(H):0]   ROI_W,
    input  logic [$clog2(V):0]   ROI_H,
    input  logic [1:0]           DECIM,
    output logic [DW-1:0]        DATA_OUT,
    output logic                 PIXEL_VALID,
    output logic [$clog2(H)-1:0] X_OUT,
    output logic [$clog2(V)-1:0] Y_OUT,
    output logic                 FRAME_START,
    output logic                 FRAME_END,
    output logic [FCW-1:0]       FRAME_COUNT,
    output logic                 LINE_ERR
);

    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    cam_state_e state, state_nx;
    logic       start_nx, end_nx;
    logic       fv_q, lv_q;
    logic       fv_rise, fv_fall, lv_fall;

    logic [XW:0] rx;
    logic [YW:0] ry;

    logic [XW-1:0] x0_l;
    logic [YW-1:0] y0_l;
    logic [XW:0]   w_l;
    logic [YW:0]   h_l;
    logic [1:0]    decim_l;

    logic          x_in, x_hit, y_in, y_hit, keep;
    logic [XW-1:0] x_coord;
    logic [YW-1:0] y_coord;

    logic [DW-1:0]  data_p1;
    logic           vld_p1;
    logic [XW-1:0]  x_p1;
    logic [YW-1:0]  y_p1;
    logic           fs_p1, fe_p1;
    logic [FCW-1:0] fcnt_p1;

    assign fv_rise = FRAME_VALID & ~fv_q;
    assign fv_fall = ~FRAME_VALID & fv_q;
    assign lv_fall = ~LINE_VALID & lv_q;

    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        end_nx   = 1'b0;
        case (state)
            SYNC:   if (!FRAME_VALID) state_nx = IDLE;
            IDLE:   if (fv_rise) begin
                        state_nx = ACTIVE;
                        start_nx = 1'b1;
                    end
            ACTIVE: if (fv_fall) begin
                        state_nx = IDLE;
                        end_nx   = 1'b1;
                    end
            default: state_nx = SYNC;
        endcase
    end

    roi_axis #(.CW(XW)) u_x_axis (
        .pos       (rx),
        .origin    (x0_l),
        .extent    (w_l),
        .decim     (decim_l),
        .in_win    (x_in),
        .phase_hit (x_hit),
        .coord     (x_coord)
    );

    roi_axis #(.CW(YW)) u_y_axis (
        .pos       (ry),
        .origin    (y0_l),
        .extent    (h_l),
        .decim     (decim_l),
        .in_win    (y_in),
        .phase_hit (y_hit),
        .coord     (y_coord)
    );

    assign keep = (state == ACTIVE) && FRAME_VALID && LINE_VALID &&
                  x_in && x_hit && y_in && y_hit;

    // Window settings are frozen for the whole frame at FRAME_START.
    always_ff @(posedge PIXCLK) begin
        if (start_nx) begin
            x0_l    <= ROI_X0;
            y0_l    <= ROI_Y0;
            w_l     <= ROI_W;
            h_l     <= ROI_H;
            decim_l <= DECIM;
        end
    end

    // Stage p0 -> p1: raw counters, frame control and registered pixel outputs.
    always_ff @(posedge PIXCLK) begin
        if (!RST_N) begin
            state   <= SYNC;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            rx      <= '0;
            ry      <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            y_p1    <= '0;
            fs_p1   <= 1'b0;
            fe_p1   <= 1'b0;
            fcnt_p1 <= '0;
        end else begin
            state   <= state_nx;
            fv_q    <= FRAME_VALID;
            lv_q    <= LINE_VALID;
            data_p1 <= DATA_IN;
            vld_p1  <= keep;
            x_p1    <= x_coord;
            y_p1    <= y_coord;
            fs_p1   <= start_nx;
            fe_p1   <= end_nx;
            if (end_nx) fcnt_p1 <= fcnt_p1 + FCW'(1);
            if (start_nx) begin
                rx <= '0;
                ry <= '0;
            end else begin
                // Counters saturate so an overlong line or frame cannot alias into the window.
                if (!LINE_VALID) rx <= '0;
                else if (!(&rx)) rx <= rx + (XW+1)'(1);
                if (lv_fall && !(&ry)) ry <= ry + (YW+1)'(1);
            end
        end
    end

    assign DATA_OUT    = data_p1;
    assign PIXEL_VALID = vld_p1;
    assign X_OUT       = x_p1;
    assign Y_OUT       = y_p1;
    assign FRAME_START = fs_p1;
    assign FRAME_END   = fe_p1;
    assign FRAME_COUNT = fcnt_p1;

`ifdef CAM_LINE_CHECK_EN
    logic err_now;
    logic line_err_p1;

    assign err_now = (state == ACTIVE) &&
                     ((lv_fall && (rx != (XW+1)'(H))) || (fv_fall && LINE_VALID));

    always_ff @(posedge PIXCLK) begin
        if (!RST_N)        line_err_p1 <= 1'b0;
        else if (err_now)  line_err_p1 <= 1'b1;
        else if (start_nx) line_err_p1 <= 1'b0;
    end

    assign LINE_ERR = line_err_p1;
`else
    assign LINE_ERR = 1'b0;
`endif

endmodule
